// File: rtl/divisor_pkg.sv
// Shared constants and helpers for the multi-channel sample-clock generator.
// Holds the board clock frequency, the half-period calculator and the
// channel-index width rule used to size the write-select port.
package divisor_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Half-period register value for an output frequency f, rounded to nearest:
  // round(CLK_HZ / (2*f)) - 1.
  function automatic int unsigned half_for_hz(input int unsigned f);
    return ((CLK_HZ + f) / (2 * f)) - 1;
  endfunction

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/divisor_muestreo_multi_canal.sv
// canal_divisor: one sample-clock channel (counter, shadowed half-period,
// 50 % duty toggle and rising-edge tick).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable         channel run enable
//   sync_restart   restart the phase from cnt = 0
//   wr_en, wr_half half-period write strobe and value for this channel
//   clock_out      generated clock (registered)
//   tick           one-cycle strobe on each rising toggle (registered)
//   pend           a written half-period waits for the next falling boundary
module canal_divisor
  import divisor_pkg::*;
#(
  parameter int unsigned DIV_W        = 20,
  parameter int unsigned DEFAULT_HALF = 499999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync_restart,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_half,
  output logic             clock_out,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] act_half, act_half_n;
  logic [DIV_W-1:0] pend_half, pend_half_n;
  logic             clock_n, tick_n, pend_n;

  // Falling toggle: the only point where a new half-period may take over.
  logic at_top, boundary;
  assign at_top   = (cnt == act_half);
  assign boundary = at_top && clock_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      act_half  <= DIV_W'(DEFAULT_HALF);
      pend_half <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
      pend      <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      act_half  <= act_half_n;
      pend_half <= pend_half_n;
      clock_out <= clock_n;
      tick      <= tick_n;
      pend      <= pend_n;
    end
  end

  // Next-state: disable, then restart, then normal counting
  always_comb begin
    cnt_n       = cnt;
    act_half_n  = act_half;
    pend_half_n = pend_half;
    clock_n     = clock_out;
    tick_n      = 1'b0;
    pend_n      = pend;

    if (!enable) begin
      cnt_n   = '0;
      clock_n = 1'b0;
      pend_n  = 1'b0;
      if (wr_en) act_half_n = wr_half;
    end else if (sync_restart) begin
      // A write in the restart cycle is newer than any pending value.
      cnt_n   = '0;
      clock_n = 1'b0;
      pend_n  = 1'b0;
      if (wr_en)     act_half_n = wr_half;
      else if (pend) act_half_n = pend_half;
    end else begin
      if (at_top) begin
        cnt_n   = '0;
        clock_n = ~clock_out;
        tick_n  = ~clock_out;
      end else begin
        cnt_n = cnt + DIV_W'(1);
      end

      if (boundary) begin
        pend_n = 1'b0;
        if (wr_en)     act_half_n = wr_half;
        else if (pend) act_half_n = pend_half;
      end else if (wr_en) begin
        pend_half_n = wr_half;
        pend_n      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divisor_muestreo_multi.sv
// divisor_muestreo_multi: CH independent 50 % duty sample clocks derived from
// the 100 MHz board clock, each with a runtime-programmable half-period.
// Ports:
//   Clck_in       system clock
//   reset_Clock   asynchronous active-high reset
//   enable        per-channel run enable
//   sync_restart  pulse restarting all enabled channels in phase
//   wr_en/wr_ch/wr_half  half-period write (out-of-range wr_ch is ignored)
//   Clock_out     generated clocks
//   tick          one-cycle strobe when Clock_out[i] rises
//   pend          channel i holds a write waiting for its period boundary
module divisor_muestreo_multi
  import divisor_pkg::*;
#(
  parameter  int unsigned CH           = 4,
  parameter  int unsigned DIV_W        = 20,
  parameter  int unsigned DEFAULT_HALF = half_for_hz(100),
  localparam int unsigned CH_W         = ch_idx_w(CH)
) (
  input  logic             Clck_in,
  input  logic             reset_Clock,
  input  logic [CH-1:0]    enable,
  input  logic             sync_restart,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_half,
  output logic [CH-1:0]    Clock_out,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    pend
);

  // Per-channel write strobes; indices >= CH match nothing.
  logic [CH-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) wr_sel[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < int'(CH); g++) begin : g_canal
    canal_divisor #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_canal (
      .clk          (Clck_in),
      .rst          (reset_Clock),
      .enable       (enable[g]),
      .sync_restart (sync_restart),
      .wr_en        (wr_sel[g]),
      .wr_half      (wr_half),
      .clock_out    (Clock_out[g]),
      .tick         (tick[g]),
      .pend         (pend[g])
    );
  end

endmodule

// File: tb/tb_divisor_muestreo_multi.sv
// Self-checking bench for divisor_muestreo_multi. The reference model tracks,
// per channel, the position inside the current period: the output is high in
// the second half of the period and ticks at its midpoint.
module tb_divisor_muestreo_multi;

  localparam int unsigned CH    = 5;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned DEF   = 4;
  localparam int unsigned CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    enable;
  logic             sync_restart;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_half;
  logic [CH-1:0]    clock_out;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    pend;

  divisor_muestreo_multi #(
    .CH           (CH),
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (DEF)
  ) dut (
    .Clck_in      (clk),
    .reset_Clock  (rst),
    .enable       (enable),
    .sync_restart (sync_restart),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_half      (wr_half),
    .Clock_out    (clock_out),
    .tick         (tick),
    .pend         (pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: position since period start, active half, pending write.
  int m_pos [CH];
  int m_act [CH];
  int m_ph  [CH];
  bit m_pv  [CH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(CH); i++) begin
      m_pos[i] = 0;
      m_act[i] = int'(DEF);
      m_ph[i]  = 0;
      m_pv[i]  = 1'b0;
    end
  endfunction

  // One clock edge of the reference model using the inputs present at the edge.
  function automatic void model_edge();
    for (int i = 0; i < int'(CH); i++) begin
      bit wr;
      wr = wr_en && (int'(wr_ch) == i);
      if (!enable[i]) begin
        m_pos[i] = 0;
        m_pv[i]  = 1'b0;
        if (wr) m_act[i] = int'(wr_half);
      end else if (sync_restart) begin
        m_pos[i] = 0;
        if (wr)           m_act[i] = int'(wr_half);
        else if (m_pv[i]) m_act[i] = m_ph[i];
        m_pv[i] = 1'b0;
      end else begin
        m_pos[i]++;
        if (m_pos[i] == 2 * (m_act[i] + 1)) begin
          m_pos[i] = 0;
          if (wr)           m_act[i] = int'(wr_half);
          else if (m_pv[i]) m_act[i] = m_ph[i];
          m_pv[i] = 1'b0;
        end else if (wr) begin
          m_ph[i] = int'(wr_half);
          m_pv[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic compare_model();
    logic [CH-1:0] ec, et, ep;
    for (int i = 0; i < int'(CH); i++) begin
      ec[i] = (m_pos[i] >= m_act[i] + 1);
      et[i] = (m_pos[i] == m_act[i] + 1);
      ep[i] = m_pv[i];
    end
    check_eq("clock_out", 32'(clock_out), 32'(ec));
    check_eq("tick", 32'(tick), 32'(et));
    check_eq("pend", 32'(pend), 32'(ep));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    compare_model();
  endtask

  task automatic write(input int ch, input int half);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_half = DIV_W'(half);
    step();
    wr_en   = 1'b0;
  endtask

  int halves [4] = '{2, 3, 4, 6};
  int rise_at [4];
  bit found;

  initial begin
    rst          = 1'b1;
    enable       = '1;
    sync_restart = 1'b0;
    wr_en        = 1'b0;
    wr_ch        = '0;
    wr_half      = '0;
    model_reset();

    // Reset and defaults
    #3;
    check_eq("reset_clock_out", 32'(clock_out), 32'h0);
    check_eq("reset_tick", 32'(tick), 32'h0);
    repeat (3) step();
    rst = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 4)  check_eq("pre_first_rise", 32'(clock_out), 32'h0);
      if (n == 5)  check_eq("first_rise", 32'(clock_out), 32'h1f);
      if (n == 5)  check_eq("first_tick", 32'(tick), 32'h1f);
      if (n == 10) check_eq("first_fall", 32'(clock_out), 32'h0);
      if (n == 15) check_eq("second_rise", 32'(tick), 32'h1f);
    end

    // Deferred write on channel 1 in the middle of its high phase
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (tick[1]) found = 1'b1;
    end
    check_eq("wait_ch1_rise", 32'(found), 32'h1);
    repeat (2) step();
    write(1, 9);
    check_eq("deferred_pend", 32'(pend[1]), 32'h1);
    check_eq("deferred_still_high", 32'(clock_out[1]), 32'h1);
    repeat (45) step();

    // Disable channel 2 while high, then re-enable
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (clock_out[2]) found = 1'b1;
    end
    check_eq("wait_ch2_high", 32'(found), 32'h1);
    enable[2] = 1'b0;
    step();
    check_eq("disable_truncates", 32'(clock_out[2]), 32'h0);
    check_eq("disable_no_tick", 32'(tick[2]), 32'h0);
    repeat (3) step();
    enable[2] = 1'b1;
    repeat (12) step();

    // Phase alignment after sync_restart
    for (int i = 0; i < 4; i++) write(i, halves[i]);
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check_eq("sync_all_low", 32'(clock_out), 32'h0);
    rise_at = '{0, 0, 0, 0};
    for (int n = 1; n <= 8; n++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (clock_out[i] && rise_at[i] == 0) rise_at[i] = n;
    end
    for (int i = 0; i < 4; i++) check_eq("align_rise", 32'(rise_at[i]), 32'(halves[i] + 1));

    // Half-period zero on a disabled channel
    enable[3] = 1'b0;
    step();
    write(3, 0);
    enable[3] = 1'b1;
    step();
    check_eq("half0_high", 32'(clock_out[3]), 32'h1);
    check_eq("half0_tick", 32'(tick[3]), 32'h1);
    step();
    check_eq("half0_low", 32'(clock_out[3]), 32'h0);
    repeat (6) step();

    // Out-of-range channel writes
    write(5, 1);
    write(7, 0);
    check_eq("bad_ch_no_pend", 32'(pend), 32'h0);
    repeat (12) step();

    // Write landing exactly on channel 0's falling boundary
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      if (m_pos[0] + 1 == 2 * (m_act[0] + 1)) found = 1'b1;
      else step();
    end
    check_eq("wait_ch0_boundary", 32'(found), 32'h1);
    write(0, 5);
    check_eq("boundary_write_no_pend", 32'(pend[0]), 32'h0);
    check_eq("boundary_write_low", 32'(clock_out[0]), 32'h0);
    repeat (14) step();

    // Randomized traffic with one asynchronous reset
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < int'(CH); i++)
        enable[i] = ($urandom_range(0, 15) != 0);
      sync_restart = ($urandom_range(0, 39) == 0);
      wr_en        = ($urandom_range(0, 5) == 0);
      wr_ch        = CH_W'($urandom_range(0, 7));
      wr_half      = DIV_W'($urandom_range(0, 7));
      if (n == 400) begin
        rst = 1'b1;
        #1;
        check_eq("async_reset_clock_out", 32'(clock_out), 32'h0);
        check_eq("async_reset_pend", 32'(pend), 32'h0);
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
